// File: rtl/tpg_frame_sequencer.sv
// Raster timing, frame strobe and frame-aligned pattern-select scheduling for the test pattern generator.
// Optional macro TPG_FRAME_NUMBER_EN adds a free-running 16-bit frame number output.
module tpg_frame_sequencer #(
    parameter int TOTAL_COLUMNS      = 1280,
    parameter int TOTAL_ROWS         = 720,
    parameter int H_FRONT            = 110,
    parameter int H_SYNC             = 40,
    parameter int H_BACK             = 220,
    parameter int V_FRONT            = 5,
    parameter int V_SYNC             = 5,
    parameter int V_BACK             = 20,
    parameter int FRAMES_PER_PATTERN = 60,
    localparam int H_TOTAL = TOTAL_COLUMNS + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL = TOTAL_ROWS + V_FRONT + V_SYNC + V_BACK,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_next,
    input  logic          i_auto,
    output logic [HW-1:0] o_hcount,
    output logic [VW-1:0] o_vcount,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_active_draw,
    output logic          o_new_frame,
    output logic [1:0]    o_sel
`ifdef TPG_FRAME_NUMBER_EN
    ,
    output logic [15:0]   o_frame_num
`endif
);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_STROBE = HW'(TOTAL_COLUMNS);
    localparam logic [VW-1:0] V_STROBE = VW'(TOTAL_ROWS);
    localparam int HS_START = TOTAL_COLUMNS + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = TOTAL_ROWS + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int FCW      = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_PATTERN - 1);

    logic [HW-1:0]  r_hcount;
    logic [VW-1:0]  r_vcount;
    logic           r_hsync;
    logic           r_vsync;
    logic           r_active_draw;
    logic           r_new_frame;
    logic [1:0]     r_sel;
    logic           r_pending;
    logic           r_next_d;
    logic [FCW-1:0] r_frame_cnt;

    logic [HW-1:0]  w_hcount_nxt;
    logic [VW-1:0]  w_vcount_nxt;
    logic           w_hsync_nxt;
    logic           w_vsync_nxt;
    logic           w_active_nxt;
    logic           w_new_frame_nxt;
    logic           w_edge;
    logic           w_advance;

    // Decodes are taken from the next counter values so every registered
    // output lines up with the hcount/vcount shown in the same cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_hcount_nxt    = r_hcount + 1'b1;
        w_vcount_nxt    = r_vcount;
        if (r_hcount == H_LAST) begin
            w_hcount_nxt = '0;
            w_vcount_nxt = (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
        end
        w_hsync_nxt     = (int'(w_hcount_nxt) >= HS_START) && (int'(w_hcount_nxt) < HS_END);
        w_vsync_nxt     = (int'(w_vcount_nxt) >= VS_START) && (int'(w_vcount_nxt) < VS_END);
        w_active_nxt    = (int'(w_hcount_nxt) < TOTAL_COLUMNS) && (int'(w_vcount_nxt) < TOTAL_ROWS);
        w_new_frame_nxt = (w_hcount_nxt == H_STROBE) && (w_vcount_nxt == V_STROBE);
    end

    assign w_edge    = i_next & ~r_next_d;
    assign w_advance = r_pending | (i_auto & (r_frame_cnt == FC_LAST));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcount      <= H_LAST;
            r_vcount      <= V_LAST;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_active_draw <= 1'b0;
            r_new_frame   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_active_draw <= w_active_nxt;
            r_new_frame   <= w_new_frame_nxt;
        end
    end

    // The select only moves on the edge after the strobe, which lies in blanking.
    // An i_next edge arriving with the strobe is held over for the following frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel       <= 2'd0;
            r_pending   <= 1'b0;
            r_next_d    <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_next_d <= i_next;
            if (r_new_frame) begin
                r_pending <= w_edge;
                if (w_advance) begin
                    r_sel <= r_sel + 2'd1;
                end
            end else begin
                r_pending <= r_pending | w_edge;
            end
            if (!i_auto) begin
                r_frame_cnt <= '0;
            end else if (r_new_frame) begin
                r_frame_cnt <= w_advance ? '0 : r_frame_cnt + 1'b1;
            end
        end
    end

`ifdef TPG_FRAME_NUMBER_EN
    logic [15:0] r_frame_num;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_num <= 16'd0;
        end else if (r_new_frame) begin
            r_frame_num <= r_frame_num + 16'd1;
        end
    end

    assign o_frame_num = r_frame_num;
`endif

    assign o_hcount      = r_hcount;
    assign o_vcount      = r_vcount;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_active_draw = r_active_draw;
    assign o_new_frame   = r_new_frame;
    assign o_sel         = r_sel;

endmodule
